// File: rtl/core_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared RV32 core constants: load/store funct3 codes, MEM FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_fsm_e;

endpackage
`default_nettype wire

// File: rtl/data_mem_be.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : data_mem_be
// Description : Data memory, synchronous byte-enable write, combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_be #(
    parameter int XLEN       = 32,
    parameter int DMEM_WORDS = 1024
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [XLEN/8-1:0]             be,
    input  logic [$clog2(DMEM_WORDS)-1:0] addr,
    input  logic [XLEN-1:0]               wdata,
    output logic [XLEN-1:0]               rdata
);

    localparam int c_lanes = XLEN / 8;

    logic [XLEN-1:0] r_mem [DMEM_WORDS];

    assign rdata = r_mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < c_lanes; i++) begin
                if (be[i]) begin
                    r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_stage_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : memory_stage_lsu
// Description : RV32 MEM stage with wait-state FSM and MEM/WB pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage_lsu
    import core_pkg::*;
#(
    parameter int XLEN        = core_pkg::XLEN,
    parameter int DMEM_WORDS  = 1024,
    parameter int WAIT_STATES = 0,
    parameter int REG_AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              MemReadM,
    input  logic              ResultSrcM,
    input  logic [2:0]        Funct3M,
    input  logic [REG_AW-1:0] RD_M,
    input  logic [XLEN-1:0]   PCPlus4M,
    input  logic [XLEN-1:0]   WriteDataM,
    input  logic [XLEN-1:0]   ALU_ResultM,
    input  logic              FlushW,
    output logic              StallReqM,
    output logic              MisalignM,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [REG_AW-1:0] RD_W,
    output logic [XLEN-1:0]   PCPlus4W,
    output logic [XLEN-1:0]   ALU_ResultW,
    output logic [XLEN-1:0]   ReadDataW
);

    localparam int         c_idx_w    = $clog2(DMEM_WORDS);
    localparam logic [3:0] c_wait     = 4'(WAIT_STATES);
    localparam bit         c_has_wait = (WAIT_STATES != 0);

    logic                 w_access;
    logic                 w_misalign;
    logic                 w_aligned_access;
    logic                 w_stall;
    logic                 w_final;
    logic                 w_mem_we;
    logic [XLEN/8-1:0]    w_be;
    logic [XLEN-1:0]      w_wdata;
    logic [XLEN-1:0]      w_rdata;
    logic [XLEN-1:0]      w_lane;
    logic [XLEN-1:0]      w_load_data;
    logic [c_idx_w-1:0]   w_index;
    logic                 w_unused;

    mem_fsm_e             r_state;
    mem_fsm_e             w_state_nxt;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_nxt;

    logic                 r_reg_write_w;
    logic                 r_result_src_w;
    logic [REG_AW-1:0]    r_rd_w;
    logic [XLEN-1:0]      r_pc_plus4_w;
    logic [XLEN-1:0]      r_alu_result_w;
    logic [XLEN-1:0]      r_read_data_w;

    assign w_access = MemReadM | MemWriteM;

    always_comb begin
        w_misalign = 1'b0;
        case (Funct3M)
            F3_H, F3_HU: w_misalign = ALU_ResultM[0];
            F3_W:        w_misalign = |ALU_ResultM[1:0];
            default:     w_misalign = 1'b0;
        endcase
    end

    assign w_aligned_access = w_access & ~w_misalign;
    assign MisalignM        = w_access & w_misalign;

    // w_final marks the cycle in which memory commits and W takes real fields.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_final     = 1'b1;
        if (c_has_wait) begin
            case (r_state)
                IDLE: begin
                    if (w_aligned_access) begin
                        w_stall     = 1'b1;
                        w_final     = 1'b0;
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 4'd1;
                    end
                end
                WAIT: begin
                    if (r_cnt < c_wait) begin
                        w_stall   = 1'b1;
                        w_final   = 1'b0;
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    assign StallReqM = w_stall & ~rst;

    always_comb begin
        w_be    = '0;
        w_wdata = WriteDataM;
        case (Funct3M)
            F3_B: begin
                w_be    = 4'b0001 << ALU_ResultM[1:0];
                w_wdata = {4{WriteDataM[7:0]}};
            end
            F3_H: begin
                w_be    = 4'b0011 << {ALU_ResultM[1], 1'b0};
                w_wdata = {2{WriteDataM[15:0]}};
            end
            F3_W:    w_be = 4'b1111;
            default: w_be = '0;
        endcase
    end

    assign w_mem_we = MemWriteM & ~w_misalign & w_final;
    assign w_index  = ALU_ResultM[c_idx_w+1:2];

    data_mem_be #(
        .XLEN       (XLEN),
        .DMEM_WORDS (DMEM_WORDS)
    ) u_dmem (
        .clk   (clk),
        .we    (w_mem_we),
        .be    (w_be),
        .addr  (w_index),
        .wdata (w_wdata),
        .rdata (w_rdata)
    );

    assign w_lane = w_rdata >> {ALU_ResultM[1:0], 3'b000};

    always_comb begin
        case (Funct3M)
            F3_B:    w_load_data = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
            F3_BU:   w_load_data = {{(XLEN-8){1'b0}}, w_lane[7:0]};
            F3_H:    w_load_data = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            F3_HU:   w_load_data = {{(XLEN-16){1'b0}}, w_lane[15:0]};
            F3_W:    w_load_data = w_rdata;
            default: w_load_data = '0;
        endcase
    end

    // Bubbles keep the other fields flowing; only RegWriteW is forced low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= 4'd0;
            r_reg_write_w  <= 1'b0;
            r_result_src_w <= 1'b0;
            r_rd_w         <= '0;
            r_pc_plus4_w   <= '0;
            r_alu_result_w <= '0;
            r_read_data_w  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_reg_write_w  <= w_final & RegWriteM & ~FlushW & ~(MemReadM & w_misalign);
            r_result_src_w <= ResultSrcM;
            r_rd_w         <= RD_M;
            r_pc_plus4_w   <= PCPlus4M;
            r_alu_result_w <= ALU_ResultM;
            r_read_data_w  <= w_load_data;
        end
    end

    assign RegWriteW   = r_reg_write_w;
    assign ResultSrcW  = r_result_src_w;
    assign RD_W        = r_rd_w;
    assign PCPlus4W    = r_pc_plus4_w;
    assign ALU_ResultW = r_alu_result_w;
    assign ReadDataW   = r_read_data_w;

    assign w_unused = ^{ALU_ResultM[XLEN-1:c_idx_w+2], w_lane[XLEN-1:16]};

endmodule
`default_nettype wire
